// File: rtl/mem_wb_skid_reg.sv
// MEM/WB pipeline register with valid/ready handshake and a two-entry skid buffer.
// Optional stall-cycle counter enabled by defining MEM_WB_STALL_CNT_EN.
module mem_wb_skid_reg #(
  parameter int XLEN  = 32,
  parameter int MLEN  = 128,
  parameter int RDW   = 5,
  parameter int WSELW = 2,
  parameter int CNTW  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             me_valid,
  output logic             me_ready,
  input  logic [XLEN-1:0]  me_mem_data,
  input  logic [XLEN-1:0]  me_alu_o,
  input  logic [MLEN-1:0]  me_matrix_o,
  input  logic [RDW-1:0]   me_rd,
  input  logic             me_mem2reg,
  input  logic [WSELW-1:0] me_w_select,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [XLEN-1:0]  wb_mem_data,
  output logic [XLEN-1:0]  wb_alu_o,
  output logic [MLEN-1:0]  wb_matrix_o,
  output logic [RDW-1:0]   wb_rd,
  output logic             wb_mem2reg,
  output logic [WSELW-1:0] wb_w_select,
  output logic [CNTW-1:0]  stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]  mem_data;
    logic [XLEN-1:0]  alu_o;
    logic [MLEN-1:0]  matrix_o;
    logic [RDW-1:0]   rd;
    logic             mem2reg;
    logic [WSELW-1:0] w_select;
  } payload_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t   state_q, state_d;
  payload_t main_q, main_d;
  payload_t skid_q, skid_d;
  payload_t in_pl;
  logic     accept;
  logic     consume;

  assign in_pl = '{
    mem_data: me_mem_data,
    alu_o:    me_alu_o,
    matrix_o: me_matrix_o,
    rd:       me_rd,
    mem2reg:  me_mem2reg,
    w_select: me_w_select
  };

  // Ready comes from the state register only, so wb_ready never reaches MEM combinationally.
  assign me_ready = (state_q != S_TWO);
  assign wb_valid = (state_q != S_EMPTY);
  assign accept   = me_valid && me_ready;
  assign consume  = wb_valid && wb_ready;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            main_d  = in_pl;
            state_d = S_ONE;
          end
        end
        S_ONE: begin
          if (accept && consume) begin
            main_d = in_pl;
          end else if (accept) begin
            skid_d  = in_pl;
            state_d = S_TWO;
          end else if (consume) begin
            main_d  = '0;
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          // The skid entry is always older than anything accepted later.
          if (consume) begin
            main_d  = skid_q;
            skid_d  = '0;
            state_d = S_ONE;
          end
        end
        default: begin
          state_d = S_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_EMPTY;
      // NOTE: payload registers are reset because idle outputs must read as zero.
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign wb_mem_data = main_q.mem_data;
  assign wb_alu_o    = main_q.alu_o;
  assign wb_matrix_o = main_q.matrix_o;
  assign wb_rd       = main_q.rd;
  assign wb_mem2reg  = main_q.mem2reg;
  assign wb_w_select = main_q.w_select;

`ifdef MEM_WB_STALL_CNT_EN
  logic [CNTW-1:0] stall_q;

  // Saturates so a long stall never wraps to a misleadingly small count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (wb_valid && !wb_ready && (stall_q != {CNTW{1'b1}})) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_wb_skid_reg.sv
// Self-checking bench for mem_wb_skid_reg: a queue scoreboard models occupancy,
// ordering, handshake outputs, zero-payload rule and the stall counter.
module tb_mem_wb_skid_reg;

  localparam int XLEN  = 32;
  localparam int MLEN  = 128;
  localparam int RDW   = 5;
  localparam int WSELW = 2;
  localparam int CNTW  = 32;

  typedef struct packed {
    logic [XLEN-1:0]  mem_data;
    logic [XLEN-1:0]  alu_o;
    logic [MLEN-1:0]  matrix_o;
    logic [RDW-1:0]   rd;
    logic             mem2reg;
    logic [WSELW-1:0] w_select;
  } payload_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             me_valid;
  logic             me_ready;
  logic [XLEN-1:0]  me_mem_data;
  logic [XLEN-1:0]  me_alu_o;
  logic [MLEN-1:0]  me_matrix_o;
  logic [RDW-1:0]   me_rd;
  logic             me_mem2reg;
  logic [WSELW-1:0] me_w_select;
  logic             wb_valid;
  logic             wb_ready;
  logic [XLEN-1:0]  wb_mem_data;
  logic [XLEN-1:0]  wb_alu_o;
  logic [MLEN-1:0]  wb_matrix_o;
  logic [RDW-1:0]   wb_rd;
  logic             wb_mem2reg;
  logic [WSELW-1:0] wb_w_select;
  logic [CNTW-1:0]  stall_cnt;

  int checks   = 0;
  int failures = 0;

  payload_t        sb_q[$];
  logic [CNTW-1:0] exp_stall = '0;

  always #5 clk = ~clk;

  mem_wb_skid_reg #(
    .XLEN(XLEN), .MLEN(MLEN), .RDW(RDW), .WSELW(WSELW), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .me_valid(me_valid), .me_ready(me_ready),
    .me_mem_data(me_mem_data), .me_alu_o(me_alu_o), .me_matrix_o(me_matrix_o),
    .me_rd(me_rd), .me_mem2reg(me_mem2reg), .me_w_select(me_w_select),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_mem_data(wb_mem_data), .wb_alu_o(wb_alu_o), .wb_matrix_o(wb_matrix_o),
    .wb_rd(wb_rd), .wb_mem2reg(wb_mem2reg), .wb_w_select(wb_w_select),
    .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic payload_t mk(input logic [XLEN-1:0] alu, input logic [RDW-1:0] rd,
                                  input logic [MLEN-1:0] mat);
    payload_t p;
    p.mem_data = alu ^ 32'h5A5A_0000;
    p.alu_o    = alu;
    p.matrix_o = mat;
    p.rd       = rd;
    p.mem2reg  = alu[0];
    p.w_select = alu[2:1];
    return p;
  endfunction

  // One clock: drive inputs, compare outputs against the model, then advance model and DUT.
  task automatic cycle(input logic v, input payload_t p, input logic rdy, input logic fl);
    payload_t        obs;
    payload_t        exp_pl;
    logic [CNTW-1:0] exp_cnt;
    logic            acc;
    logic            cons;
    me_valid    = v;
    me_mem_data = p.mem_data;
    me_alu_o    = p.alu_o;
    me_matrix_o = p.matrix_o;
    me_rd       = p.rd;
    me_mem2reg  = p.mem2reg;
    me_w_select = p.w_select;
    wb_ready    = rdy;
    flush       = fl;
    #1;
    obs = '{wb_mem_data, wb_alu_o, wb_matrix_o, wb_rd, wb_mem2reg, wb_w_select};
    exp_pl = (sb_q.size() > 0) ? sb_q[0] : '0;
`ifdef MEM_WB_STALL_CNT_EN
    exp_cnt = exp_stall;
`else
    exp_cnt = '0;
`endif
    check("wb_valid", 256'(wb_valid), 256'(sb_q.size() != 0));
    check("me_ready", 256'(me_ready), 256'(sb_q.size() != 2));
    check("wb_payload", 256'(obs), 256'(exp_pl));
    check("stall_cnt", 256'(stall_cnt), 256'(exp_cnt));
    acc  = v && (sb_q.size() < 2) && !fl;
    cons = (sb_q.size() > 0) && rdy && !fl;
    if ((sb_q.size() > 0) && !rdy) exp_stall++;
    if (cons) void'(sb_q.pop_front());
    if (acc) sb_q.push_back(p);
    if (fl) sb_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, rdy, 1'b0);
  endtask

  task automatic reset_cycle();
    rst      = 1'b0;
    me_valid = 1'b0;
    flush    = 1'b0;
    wb_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb_q.delete();
    exp_stall = '0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; me_valid = 1'b0; wb_ready = 1'b0;
    me_mem_data = '0; me_alu_o = '0; me_matrix_o = '0;
    me_rd = '0; me_mem2reg = 1'b0; me_w_select = '0;
    @(posedge clk);
    #1;
    reset_cycle();
    idle(1'b1, 1);

    // Back-to-back stream with WB always ready.
    cycle(1'b1, mk(32'h11, 5'd1, 128'h1), 1'b1, 1'b0);
    check("stream_lat1_valid", 256'(wb_valid), 256'(1));
    cycle(1'b1, mk(32'h22, 5'd2, 128'h2), 1'b1, 1'b0);
    cycle(1'b1, mk(32'h33, 5'd3, 128'h3), 1'b1, 1'b0);
    idle(1'b1, 2);

    // Backpressure fills the skid; input ignored while full; ordered drain.
    cycle(1'b1, mk(32'hA5, 5'd5, 128'hA), 1'b0, 1'b0);
    cycle(1'b1, mk(32'hB6, 5'd6, 128'hB), 1'b0, 1'b0);
    check("full_me_ready", 256'(me_ready), 256'(0));
    cycle(1'b1, mk(32'h77, 5'd7, 128'h7), 1'b0, 1'b0);
    idle(1'b1, 3);

    // Long stall: outputs hold, counter tracks ten stalled edges.
    cycle(1'b1, mk(32'hA1, 5'd9, 128'hA1), 1'b0, 1'b0);
    cycle(1'b1, mk(32'hB1, 5'd10, 128'hB1), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, mk(32'hEE, 5'd11, 128'hE), 1'b0, 1'b0);

    // Flush while full with a valid input: everything discarded.
    cycle(1'b1, mk(32'hCC, 5'd12, 128'hC), 1'b0, 1'b1);
    check("flush_wb_valid", 256'(wb_valid), 256'(0));
    check("flush_matrix", 256'(wb_matrix_o), 256'(0));
    idle(1'b1, 2);

    // Reset while holding one entry with an all-ones matrix result.
    cycle(1'b1, mk(32'h5C, 5'd13, {MLEN{1'b1}}), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0);
    reset_cycle();
    check("rst_matrix", 256'(wb_matrix_o), 256'(0));
    check("rst_stall", 256'(stall_cnt), 256'(0));
    idle(1'b1, 1);

    // Reset while full.
    cycle(1'b1, mk(32'h61, 5'd14, 128'h61), 1'b0, 1'b0);
    cycle(1'b1, mk(32'h62, 5'd15, 128'h62), 1'b0, 1'b0);
    reset_cycle();
    idle(1'b1, 2);

    // Simultaneous consume and accept in ONE: no bubble.
    cycle(1'b1, mk(32'hD0, 5'd16, 128'hD), 1'b0, 1'b0);
    cycle(1'b1, mk(32'hE0, 5'd17, 128'hE0), 1'b1, 1'b0);
    check("pass_through_alu", 256'(wb_alu_o), 256'(32'hE0));
    idle(1'b1, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_skid_reg.md
Name: mem_wb_skid_reg

Overview:
- Parametrised MEM/WB pipeline stage with a valid/ready handshake and a two-entry skid buffer, so writeback backpressure never creates a combinational path back into MEM.
- Carries the scalar load data, ALU result, matrix result, destination register and writeback select fields.
- Adds flush (bubble insertion) and an optional stall-cycle counter.
- Sits between the memory stage and the register-file / matrix-register writeback logic.

Parameters:
- XLEN, 32, width of mem_data and alu_o.
- MLEN, 128, width of matrix_o.
- RDW, 5, destination register index width.
- WSELW, 2, writeback select width.
- CNTW, 32, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- flush  in  1  discard all held and incoming entries.
- me_valid  in  1  MEM payload valid.
- me_ready  out  1  stage can accept a payload.
- me_mem_data  in  XLEN  load data.
- me_alu_o  in  XLEN  ALU result.
- me_matrix_o  in  MLEN  matrix unit result.
- me_rd  in  RDW  destination register.
- me_mem2reg  in  1  select load data over ALU result.
- me_w_select  in  WSELW  writeback target select.
- wb_valid  out  1  WB payload valid.
- wb_ready  in  1  WB consumes payload.
- wb_mem_data  out  XLEN
- wb_alu_o  out  XLEN
- wb_matrix_o  out  MLEN
- wb_rd  out  RDW
- wb_mem2reg  out  1
- wb_w_select  out  WSELW
- stall_cnt  out  CNTW  count of cycles with wb_valid=1 and wb_ready=0.

Behaviour:
- Storage: main entry (drives wb_*) and skid entry; all outputs registered.
- State: EMPTY (none held), ONE (main held), TWO (main and skid held).
- wb_valid = (state != EMPTY).
- me_ready = (state != TWO). It depends only on the state register; no path from wb_ready.
- Input accept = me_valid && me_ready. Output consume = wb_valid && wb_ready.
- EMPTY:
  - accept -> main <= input, go to ONE.
  - otherwise stay EMPTY.
- ONE:
  - accept and consume -> main <= input, stay ONE.
  - accept only -> skid <= input, go to TWO.
  - consume only -> main <= 0, go to EMPTY.
  - neither -> hold.
- TWO:
  - consume -> main <= skid, skid <= 0, go to ONE.
  - otherwise hold.
  - me_valid is ignored in TWO.
- Latency: 1 cycle from accept to wb_valid when the stage is EMPTY or draining. Throughput is 1 per cycle while wb_ready=1.
- Ordering is strict FIFO: the skid entry is always older than any later accept.
- Payload rule: all wb_* payload fields are 0 whenever wb_valid=0.
- Flush (highest priority after reset):
  - Next cycle: state = EMPTY, both entries 0, me_ready = 1.
  - An input presented in the flush cycle is dropped even if me_valid=1.
  - stall_cnt is unaffected.
- Reset (rst=0, any cycle, including mid-transfer or while in TWO):
  - Next edge: state = EMPTY, all wb_* = 0, wb_valid = 0, me_ready = 1, stall_cnt = 0.
  - In-flight entries are lost.
- stall_cnt: increments on each edge where wb_valid && !wb_ready, and saturates at all-ones.

Optional Feature:
- Macro MEM_WB_STALL_CNT_EN.
- Defined: stall_cnt counter is implemented as described.
- Undefined: no counter flops; stall_cnt is tied to 0.
- The port list is identical in both builds.

Test Plan:
- Reset, then 3 back-to-back payloads (alu_o = 0x11, 0x22, 0x33) with wb_ready=1 -> wb_valid high for 3 consecutive cycles starting 1 cycle after the first accept, same order; me_ready stays 1.
- Payload A (rd=5, alu_o=0xA5), then B (rd=6) with wb_ready=0 -> state TWO and me_ready=0 after B. Raise wb_ready -> A then B drain in order; me_ready returns to 1 one cycle after A is consumed.
- Fill to TWO, hold wb_ready=0 for 10 cycles -> wb_* stable at A. With MEM_WB_STALL_CNT_EN, stall_cnt advances by exactly 10 over that window; without it, stall_cnt stays 0.
- Fill to TWO, assert flush while me_valid=1 with C (alu_o=0xCC) -> next cycle wb_valid=0, all wb_* = 0, me_ready=1; C never appears at the output.
- In state ONE with matrix_o = 128'hFFFF...F, drive rst=0 for 1 cycle -> next cycle wb_valid=0, wb_matrix_o=0, stall_cnt=0.
- Consume and accept in the same cycle in state ONE (main=D, input E) -> next cycle wb_* = E, state stays ONE, no bubble.
